// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared types, defaults and helpers for the pipeline latch chain.
package pipe_ctrl_chain_pkg;

    // Payload layout carried by every stage; the chain itself treats it as opaque bits.
    typedef struct packed {
        logic [15:0] ctl;
        logic [15:0] addr;
        logic [15:0] sval;
        logic [15:0] dval;
    } payload_t;

    localparam int NSTAGES_DEF = 4;
    localparam int DW_DEF      = $bits(payload_t);
    localparam int TW_DEF      = 3;
    localparam int CNTW_DEF    = 32;

    // Per-stage register action selected by the hold chain.
    typedef enum logic {
        SLOT_LOAD = 1'b0,
        SLOT_HOLD = 1'b1
    } slot_op_e;

    // Number of bits needed to represent values 0..n-1.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_chain_slot.sv
// One pipeline stage: valid, payload and destination tag with load/hold/kill selection.
module pipe_slot
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          r,
    input  slot_op_e      op,
    input  logic          kill,
    input  logic          ld_v,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_tag_v,
    input  logic [TW-1:0] ld_tag,
    output logic          v,
    output logic [DW-1:0] data,
    output logic          tag_v,
    output logic [TW-1:0] tag
);

    // Stage register: reset clears everything, hold keeps fields but honours kill, load takes upstream.
    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (!r) begin
            v     <= 1'b0;
            data  <= '0;
            tag_v <= 1'b0;
            tag   <= '0;
        end else if (op == SLOT_HOLD) begin
            v <= v & ~kill;
        end else begin
            v     <= ld_v;
            data  <= ld_data;
            tag_v <= ld_tag_v;
            tag   <= ld_tag;
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// N-stage pipeline latch chain with bubble-collapsing stalls, per-stage flush,
// destination-register dependency query and perf counters.
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int NSTAGES = NSTAGES_DEF,
    parameter int DW      = DW_DEF,
    parameter int TW      = TW_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic                           clk,
    input  logic                           r,
    input  logic                           in_v,
    input  logic [DW-1:0]                  in_data,
    input  logic                           in_tag_v,
    input  logic [TW-1:0]                  in_tag,
    output logic                           in_ready,
    input  logic [NSTAGES-1:0]             stall,
    input  logic [NSTAGES-1:0]             flush_mask,
    input  logic                           flush_in,
    output logic [NSTAGES-1:0]             stg_v,
    output logic [NSTAGES*DW-1:0]          stg_data,
    output logic                           out_v,
    input  logic                           q_v,
    input  logic [TW-1:0]                  q_tag,
    output logic [NSTAGES-1:0]             dep_vec,
    output logic                           dep_hit,
    output logic [clog2(NSTAGES+1)-1:0]    occ,
    output logic [CNTW-1:0]                stall_cnt,
    output logic [CNTW-1:0]                retire_cnt
);

    localparam int OCCW = clog2(NSTAGES + 1);

    logic [NSTAGES-1:0] v;
    logic [NSTAGES-1:0] ve;
    logic [NSTAGES-1:0] hold;
    logic [NSTAGES-1:0] tag_v;
    logic [NSTAGES-1:0] ld_v;
    logic [NSTAGES-1:0] ld_tag_v;
    logic [DW-1:0]      data    [NSTAGES];
    logic [DW-1:0]      ld_data [NSTAGES];
    logic [TW-1:0]      tag     [NSTAGES];
    logic [TW-1:0]      ld_tag  [NSTAGES];

    // A flushed stage is treated as empty everywhere, so it can never hold.
    assign ve       = v & ~flush_mask;
    assign stg_v    = ve;
    assign in_ready = ~hold[0];
    assign out_v    = ve[NSTAGES-1] & ~stall[NSTAGES-1];

    // Hold chain from writeback backwards: an occupied stage holds if it or anything below it is stuck.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        logic h;
        hold = '0;
        h    = 1'b0;
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            h       = ve[i] & (stall[i] | h);
            hold[i] = h;
        end
    end

    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign ld_v[i]     = in_v & ~flush_in;
            assign ld_data[i]  = in_data;
            assign ld_tag_v[i] = in_tag_v;
            assign ld_tag[i]   = in_tag;
        end else begin : g_body
            // An upstream stage that stalls leaves a bubble behind rather than duplicating.
            assign ld_v[i]     = ve[i-1] & ~stall[i-1];
            assign ld_data[i]  = data[i-1];
            assign ld_tag_v[i] = tag_v[i-1];
            assign ld_tag[i]   = tag[i-1];
        end

        pipe_slot #(
            .DW (DW),
            .TW (TW)
        ) u_slot (
            .clk      (clk),
            .r        (r),
            .op       (hold[i] ? SLOT_HOLD : SLOT_LOAD),
            .kill     (flush_mask[i]),
            .ld_v     (ld_v[i]),
            .ld_data  (ld_data[i]),
            .ld_tag_v (ld_tag_v[i]),
            .ld_tag   (ld_tag[i]),
            .v        (v[i]),
            .data     (data[i]),
            .tag_v    (tag_v[i]),
            .tag      (tag[i])
        );

        assign stg_data[i*DW +: DW] = data[i];
    end

    // Dependency compare against every live destination tag, plus occupancy popcount.
    always_comb begin
        dep_vec = '0;
        occ     = '0;
        for (int i = 0; i < NSTAGES; i++) begin
            dep_vec[i] = q_v & ve[i] & tag_v[i] & (tag[i] == q_tag);
            occ        = occ + OCCW'(ve[i]);
        end
    end
    assign dep_hit = |dep_vec;

    // Perf counters: decode-blocked cycles saturate, retirements wrap.
    always_ff @(posedge clk) begin
        if (!r) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (in_v && !flush_in && !in_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNTW'(1);
            if (out_v)
                retire_cnt <= retire_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Self-checking bench for pipe_ctrl_chain: directed scenarios plus random traffic
// compared against a slot-occupancy reference model.
module tb_pipe_ctrl_chain;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int TW   = 3;
    localparam int CNTW = 4;
    localparam int OCCW = $clog2(N + 1);
    localparam int CMAX = (1 << CNTW) - 1;

    logic              clk = 1'b0;
    logic              r;
    logic              in_v;
    logic [DW-1:0]     in_data;
    logic              in_tag_v;
    logic [TW-1:0]     in_tag;
    logic              in_ready;
    logic [N-1:0]      stall;
    logic [N-1:0]      flush_mask;
    logic              flush_in;
    logic [N-1:0]      stg_v;
    logic [N*DW-1:0]   stg_data;
    logic              out_v;
    logic              q_v;
    logic [TW-1:0]     q_tag;
    logic [N-1:0]      dep_vec;
    logic              dep_hit;
    logic [OCCW-1:0]   occ;
    logic [CNTW-1:0]   stall_cnt;
    logic [CNTW-1:0]   retire_cnt;

    pipe_ctrl_chain #(
        .NSTAGES (N),
        .DW      (DW),
        .TW      (TW),
        .CNTW    (CNTW)
    ) dut (
        .clk        (clk),
        .r          (r),
        .in_v       (in_v),
        .in_data    (in_data),
        .in_tag_v   (in_tag_v),
        .in_tag     (in_tag),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush_mask (flush_mask),
        .flush_in   (flush_in),
        .stg_v      (stg_v),
        .stg_data   (stg_data),
        .out_v      (out_v),
        .q_v        (q_v),
        .q_tag      (q_tag),
        .dep_vec    (dep_vec),
        .dep_hit    (dep_hit),
        .occ        (occ),
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: slot contents plus counters.
    logic [N-1:0]  mv;
    logic [N-1:0]  mtv;
    logic [DW-1:0] md [N];
    logic [TW-1:0] mt [N];
    int            m_stall;
    int            m_retire;

    // Per-cycle predictions shared between drive and tick.
    logic [N-1:0]  e_ve;
    logic [N-1:0]  e_moves;
    logic [N-1:0]  e_stays;
    logic          e_ready;

    int            vectors;
    int            miscompares;
    int            cyc;
    logic [DW-1:0] ret_q[$];
    int            ret_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then compare every combinational output and counter against the model.
    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic itv,
                         input logic [TW-1:0] it, input logic [N-1:0] st, input logic [N-1:0] fm,
                         input logic fi, input logic qv, input logic [TW-1:0] qt);
        logic          nf;
        logic [N-1:0]  e_dep;
        logic [63:0]   mask;
        logic [63:0]   exp_d;
        r = 1'b1; in_v = iv; in_data = id; in_tag_v = itv; in_tag = it;
        stall = st; flush_mask = fm; flush_in = fi; q_v = qv; q_tag = qt;
        #1;
        // An item advances only if the slot it moves into is free at the end of this cycle.
        nf = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            e_ve[i]    = mv[i] & ~fm[i];
            e_moves[i] = e_ve[i] & ~st[i] & nf;
            e_stays[i] = e_ve[i] & ~e_moves[i];
            nf         = ~e_stays[i];
        end
        e_ready = ~e_stays[0];
        mask    = '0;
        exp_d   = '0;
        e_dep   = '0;
        for (int i = 0; i < N; i++) begin
            e_dep[i] = qv & e_ve[i] & mtv[i] & (mt[i] == qt);
            if (e_ve[i]) begin
                mask[i*DW +: DW]  = '1;
                exp_d[i*DW +: DW] = md[i];
            end
        end
        check("in_ready",   in_ready,              e_ready);
        check("out_v",      out_v,                 e_moves[N-1]);
        check("stg_v",      stg_v,                 e_ve);
        check("occ",        occ,                   $countones(e_ve));
        check("dep_vec",    dep_vec,               e_dep);
        check("dep_hit",    dep_hit,               |e_dep);
        check("stg_data",   64'(stg_data) & mask,  exp_d);
        check("stall_cnt",  stall_cnt,             m_stall);
        check("retire_cnt", retire_cnt,            m_retire);
        if (out_v) begin
            ret_q.push_back(stg_data[(N-1)*DW +: DW]);
            ret_cyc.push_back(cyc);
        end
    endtask

    // Clock edge: advance the model using the predictions made in drive.
    task automatic tick();
        @(posedge clk);
        if (in_v && !flush_in && !e_ready && m_stall != CMAX) m_stall++;
        if (e_moves[N-1]) m_retire = (m_retire + 1) % (CMAX + 1);
        for (int i = N - 1; i >= 0; i--) begin
            if (!e_stays[i]) begin
                if (i == 0) begin
                    mv[0] = in_v & ~flush_in; md[0] = in_data; mtv[0] = in_tag_v; mt[0] = in_tag;
                end else begin
                    mv[i] = e_moves[i-1]; md[i] = md[i-1]; mtv[i] = mtv[i-1]; mt[i] = mt[i-1];
                end
            end
        end
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
            tick();
        end
    endtask

    task automatic feed(input logic [DW-1:0] id, input logic [TW-1:0] it);
        drive(1'b1, id, 1'b1, it, '0, '0, 1'b0, 1'b0, '0);
        tick();
    endtask

    // Reset with busy inputs: state and counters must clear regardless.
    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            r = 1'b0; in_v = 1'b1; in_data = DW'($urandom); in_tag_v = 1'b1; in_tag = TW'($urandom);
            stall = N'($urandom); flush_mask = N'($urandom); flush_in = 1'($urandom);
            q_v = 1'b1; q_tag = TW'($urandom);
            @(posedge clk);
            mv = '0; mtv = '0; m_stall = 0; m_retire = 0;
            for (int i = 0; i < N; i++) begin md[i] = '0; mt[i] = '0; end
            #1;
            cyc++;
            check("rst_stg_v",      stg_v,      0);
            check("rst_occ",        occ,        0);
            check("rst_in_ready",   in_ready,   1);
            check("rst_out_v",      out_v,      0);
            check("rst_dep_vec",    dep_vec,    0);
            check("rst_stall_cnt",  stall_cnt,  0);
            check("rst_retire_cnt", retire_cnt, 0);
        end
    endtask

    initial begin
        logic [N-1:0] rs;
        logic [N-1:0] rf;
        vectors = 0; miscompares = 0; cyc = 0;

        // Reset held three cycles with decode presenting work.
        reset_cycles(3);

        // Streaming: eight back-to-back items, retired in order with 4-cycle latency.
        ret_q.delete(); ret_cyc.delete(); cyc = 0;
        for (int k = 0; k < 8; k++) feed(DW'(k + 1), '0);
        idle(6);
        check("stream_count", ret_q.size(), 8);
        for (int k = 0; k < ret_q.size() && k < 8; k++) check("stream_order", ret_q[k], k + 1);
        if (ret_cyc.size() == 8) begin
            check("stream_first_cyc", ret_cyc[0], 4);
            check("stream_last_cyc",  ret_cyc[7], 11);
        end
        check("stream_retire_cnt", retire_cnt, 8);

        // Bubble collapse: stages {0,2} occupied, stall at writeback.
        feed(16'h00A0, '0);
        idle(1);
        feed(16'h00B0, '0);
        drive(1'b0, '0, 1'b0, '0, 4'b1000, '0, 1'b0, 1'b0, '0);
        check("bub_pre_stg_v", stg_v, 4'b0101);
        tick();
        check("bub_post_stg_v", stg_v, 4'b1010);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, DW'(16'h00C0 + k), 1'b0, '0, 4'b1000, '0, 1'b0, 1'b0, '0);
            check("bub_fill_ready", in_ready, 1);
            tick();
        end
        drive(1'b1, 16'h00E0, 1'b0, '0, 4'b1000, '0, 1'b0, 1'b0, '0);
        check("bub_full_stg_v", stg_v, 4'b1111);
        check("bub_full_ready", in_ready, 0);
        tick();
        idle(8);

        // Mid-chain stall for one cycle on a full stream: bubble at stage 2, nothing lost.
        ret_q.delete();
        for (int k = 1; k <= 4; k++) feed(DW'(16'h0100 + k), '0);
        drive(1'b1, 16'h0105, 1'b0, '0, 4'b0010, '0, 1'b0, 1'b0, '0);
        check("mid_ready", in_ready, 0);
        tick();
        check("mid_stg_v", stg_v, 4'b1011);
        check("mid_stall_cnt", stall_cnt, 2);
        for (int k = 5; k <= 7; k++) feed(DW'(16'h0100 + k), '0);
        idle(8);
        check("mid_count", ret_q.size(), 7);
        for (int k = 0; k < ret_q.size() && k < 7; k++) check("mid_order", ret_q[k], 16'h0101 + k);

        // Flush of stages 0,1 and the incoming item while writeback stalls.
        for (int k = 0; k < 4; k++) feed(DW'(16'h0200 + k), '0);
        drive(1'b1, 16'h02FF, 1'b0, '0, 4'b1000, 4'b0011, 1'b1, 1'b0, '0);
        check("flush_ready", in_ready, 1);
        tick();
        drive(1'b0, '0, 1'b0, '0, 4'b1000, '0, 1'b0, 1'b0, '0);
        check("flush_stg_v", stg_v, 4'b1100);
        check("flush_occ", occ, 2);
        tick();
        // Flush everything at once under full stall.
        drive(1'b1, 16'h03FF, 1'b0, '0, 4'b1111, 4'b1111, 1'b1, 1'b0, '0);
        check("flush_all_ready", in_ready, 1);
        tick();
        drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        check("flush_all_stg_v", stg_v, 4'b0000);
        check("flush_all_occ", occ, 0);
        tick();

        // Dependency query: tags 5,2,5,7 in stages 0..3.
        feed(16'h0301, 3'd7);
        feed(16'h0302, 3'd5);
        feed(16'h0303, 3'd2);
        feed(16'h0304, 3'd5);
        drive(1'b0, '0, 1'b0, '0, 4'b1111, '0, 1'b0, 1'b1, 3'd5);
        check("dep_vec_5", dep_vec, 4'b0101);
        check("dep_hit_5", dep_hit, 1);
        tick();
        drive(1'b0, '0, 1'b0, '0, 4'b1111, 4'b0001, 1'b0, 1'b1, 3'd5);
        check("dep_vec_flush0", dep_vec, 4'b0100);
        tick();
        idle(6);

        // Stall counter saturation: stage 0 stuck with decode pushing.
        feed(16'h0400, '0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 16'h0401, 1'b0, '0, 4'b0001, '0, 1'b0, 1'b0, '0);
            tick();
        end
        check("stall_cnt_sat", stall_cnt, 4'hF);
        idle(6);

        // Random traffic with a reset in the middle.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) reset_cycles(2);
            for (int i = 0; i < N; i++) begin
                rs[i] = ($urandom_range(0, 3) == 0);
                rf[i] = ($urandom_range(0, 7) == 0);
            end
            drive($urandom_range(0, 3) != 0, DW'($urandom), 1'($urandom), TW'($urandom),
                  rs, rf, $urandom_range(0, 7) == 0, 1'($urandom), TW'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
